nave_ctrl: RTL

NAVE_CTRL -- requirements
Module: nave_ctrl

---
 rtl/nave_pkg.sv | 19 +
 rtl/sync_edge.sv | 33 +++
 rtl/nave_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nave_pkg.sv
// Shared game definitions for the player ship controller: state encoding,
// screen and sprite dimensions, and datapath widths.
package nave_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE     = 2'd0,
      ST_DEAD      = 2'd1,
      ST_GAME_OVER = 2'd2
   } nave_state_t;

   localparam int SCREEN_W_DEF   = 640;
   localparam int SPRITE_W_DEF   = 32;
   localparam int POS_W          = 10;
   localparam int CLAMP_W        = 11;
   localparam int CNT_W          = 8;
   localparam int SHOT_Y_OFFSET  = 8;
   localparam int START_LIVES    = 3;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-cycle
// rise and fall pulses derived from the synchronized level.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic stable;
   logic prev;

   // Metastability chain plus one delayed copy used for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta   <= 1'b0;
         stable <= 1'b0;
         prev   <= 1'b0;
      end else begin
         meta   <= din;
         stable <= meta;
         prev   <= stable;
      end
   end

   assign level = stable;
   assign rise  = stable & ~prev;
   assign fall  = ~stable & prev;

endmodule

// File: rtl/nave_ctrl.sv
// Player ship controller: per-frame movement with edge clamping, a single
// shot in flight, hit/respawn handling and a lives counter ending the game.
module nave_ctrl
   import nave_pkg::*;
#(
   parameter int SCREEN_W       = SCREEN_W_DEF,
   parameter int SPRITE_W       = SPRITE_W_DEF,
   parameter int SPEED          = 4,
   parameter int SHOT_SPEED     = 8,
   parameter int START_X        = 304,
   parameter int START_Y        = 448,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vsync,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_fire,
   input  logic             hit,
   input  logic             shot_clear,
   output logic [POS_W-1:0] sprite_x,
   output logic [POS_W-1:0] sprite_y,
   output logic [POS_W-1:0] shot_x,
   output logic [POS_W-1:0] shot_y,
   output logic             shot_active,
   output logic             ship_visible,
   output logic [1:0]       lives,
   output logic             game_over
);

   localparam logic [CLAMP_W-1:0] X_MAX       = CLAMP_W'(SCREEN_W - SPRITE_W);
   localparam logic [CLAMP_W-1:0] STEP        = CLAMP_W'(SPEED);
   localparam logic [POS_W-1:0]   SHOT_STEP   = POS_W'(SHOT_SPEED);
   localparam logic [POS_W-1:0]   SHOT_X_OFS  = POS_W'(SPRITE_W / 2 - 1);
   localparam logic [POS_W-1:0]   SHOT_Y_LOAD = POS_W'(START_Y - SHOT_Y_OFFSET);
   localparam logic [CNT_W-1:0]   RESPAWN_CNT = CNT_W'(RESPAWN_FRAMES);

   nave_state_t      state;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] cnt_dec;
   logic             fire_pending;

   logic frame_tick;
   logic left;
   logic right;
   logic fire_rise;

   logic vsync_level_unused;
   logic vsync_fall_unused;
   logic left_rise_unused;
   logic left_fall_unused;
   logic right_rise_unused;
   logic right_fall_unused;
   logic fire_level_unused;
   logic fire_fall_unused;

   logic [CLAMP_W-1:0] x_ext;
   logic [CLAMP_W-1:0] x_left;
   logic [CLAMP_W-1:0] x_right;
   logic [CLAMP_W-1:0] x_next;

   sync_edge u_sync_vsync (
      .clk   (clk),
      .reset (reset),
      .din   (vsync),
      .level (vsync_level_unused),
      .rise  (frame_tick),
      .fall  (vsync_fall_unused)
   );

   sync_edge u_sync_left (
      .clk   (clk),
      .reset (reset),
      .din   (btn_left),
      .level (left),
      .rise  (left_rise_unused),
      .fall  (left_fall_unused)
   );

   sync_edge u_sync_right (
      .clk   (clk),
      .reset (reset),
      .din   (btn_right),
      .level (right),
      .rise  (right_rise_unused),
      .fall  (right_fall_unused)
   );

   sync_edge u_sync_fire (
      .clk   (clk),
      .reset (reset),
      .din   (btn_fire),
      .level (fire_level_unused),
      .rise  (fire_rise),
      .fall  (fire_fall_unused)
   );

   assign sprite_y = POS_W'(START_Y);
   assign cnt_dec  = counter - CNT_W'(1);

   // Widened position so both clamps are computed without wrap-around.
   assign x_ext   = {1'b0, sprite_x};
   assign x_left  = (x_ext < STEP) ? '0 : x_ext - STEP;
   assign x_right = ((x_ext + STEP) > X_MAX) ? X_MAX : x_ext + STEP;

   // Horizontal move request: exactly one direction pressed moves, else hold.
   always_comb begin
      x_next = x_ext;
      if (left && !right) begin
         x_next = x_left;
      end else if (right && !left) begin
         x_next = x_right;
      end
   end

   // Game state machine with all position, shot and status outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_ALIVE;
         sprite_x     <= POS_W'(START_X);
         shot_active  <= 1'b0;
         shot_x       <= '0;
         shot_y       <= '0;
         lives        <= 2'(START_LIVES);
         game_over    <= 1'b0;
         ship_visible <= 1'b1;
         fire_pending <= 1'b0;
         counter      <= '0;
      end else begin
         if (shot_clear) begin
            shot_active <= 1'b0;
         end else if (frame_tick && shot_active) begin
            if (shot_y < SHOT_STEP) begin
               shot_active <= 1'b0;
            end else begin
               shot_y <= shot_y - SHOT_STEP;
            end
         end

         case (state)
            ST_ALIVE: begin
               if (hit) begin
                  state        <= ST_DEAD;
                  counter      <= RESPAWN_CNT;
                  ship_visible <= RESPAWN_CNT[3];
                  fire_pending <= 1'b0;
               end else begin
                  if (frame_tick) begin
                     sprite_x <= x_next[POS_W-1:0];
                     if (fire_pending) begin
                        fire_pending <= 1'b0;
                        if (!shot_active && !shot_clear) begin
                           shot_active <= 1'b1;
                           shot_x      <= sprite_x + SHOT_X_OFS;
                           shot_y      <= SHOT_Y_LOAD;
                        end
                     end
                  end
                  if (fire_rise) begin
                     fire_pending <= 1'b1;
                  end
               end
            end
            ST_DEAD: begin
               if (frame_tick) begin
                  if (counter <= CNT_W'(1)) begin
                     counter <= '0;
                     lives   <= lives - 2'd1;
                     if (lives <= 2'd1) begin
                        state        <= ST_GAME_OVER;
                        game_over    <= 1'b1;
                        ship_visible <= 1'b0;
                     end else begin
                        state        <= ST_ALIVE;
                        sprite_x     <= POS_W'(START_X);
                        ship_visible <= 1'b1;
                     end
                  end else begin
                     counter      <= cnt_dec;
                     ship_visible <= cnt_dec[3];
                  end
               end
            end
            ST_GAME_OVER: begin
               game_over    <= 1'b1;
               ship_visible <= 1'b0;
            end
            default: begin
               state <= ST_ALIVE;
            end
         endcase
      end
   end

endmodule
